// File: rtl/z80_io_pkg.sv
// Shared types and constants for the Z80 I/O bus initiator and its responders.
package z80_io_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WCNT_W = 8;

    localparam logic [WCNT_W-1:0] WAIT_LIMIT_DEF = 8'd255;
    localparam int unsigned       IDLE_GAP_DEF   = 1;

    // Register-file port map: 80h is the auto-increment window, channels span 80h..A3h.
    localparam logic [ADDR_W-1:0] BASE_ADR  = 8'h80;
    localparam logic [ADDR_W-1:0] LAST_ADR  = 8'hA3;
    localparam int unsigned       NUM_PORTS = 36;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3,
        ST_T4
    } io_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } io_cmd_t;

endpackage

// File: rtl/z80_wait_timer.sv
// Counts wait-extension cycles and flags the cycle on which the abort limit is reached.
module z80_wait_timer
    import z80_io_pkg::*;
#(
    parameter logic [WCNT_W-1:0] WAIT_LIMIT = WAIT_LIMIT_DEF
) (
    input  logic clk_cpu,
    input  logic reset_cpu,
    input  logic clear,
    input  logic count_en,
    output logic timeout_c
);

    logic [WCNT_W-1:0] cnt;

    always_ff @(posedge clk_cpu) begin
        if (!reset_cpu) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && (cnt != '1)) begin
            cnt <= cnt + WCNT_W'(1);
        end
    end

    // Fires on the TW cycle whose low wait sample would bring the count to the limit.
    assign timeout_c = count_en &&
        (((WCNT_W+1)'(cnt) + (WCNT_W+1)'(1)) >= (WCNT_W+1)'(WAIT_LIMIT));

endmodule

// File: rtl/z80_io_initiator.sv
// Z80-style I/O bus initiator: turns cmd handshakes into T1/T2/TW/T3/T4 bus cycles.
module z80_io_initiator
    import z80_io_pkg::*;
#(
    parameter logic [WCNT_W-1:0] WAIT_LIMIT = WAIT_LIMIT_DEF,
    parameter int unsigned       IDLE_GAP   = IDLE_GAP_DEF
) (
    input  logic              clk_cpu,
    input  logic              reset_cpu,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] a_cpu,
    inout  wire  [DATA_W-1:0] d_cpu,
    output logic              io_req_cpu,
    output logic              rd_cpu,
    output logic              wr_cpu,
    input  logic              wait_cpu
);

    localparam int unsigned GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;

    io_state_e        state;
    io_cmd_t          cmd_q;
    logic             d_oe;
    logic [GAP_W-1:0] gap_cnt;
    logic             timeout_c;

    assign a_cpu = cmd_q.addr;
    assign d_cpu = d_oe ? cmd_q.wdata : {DATA_W{1'bz}};

    z80_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk_cpu    (clk_cpu),
        .reset_cpu  (reset_cpu),
        .clear      (state == ST_T2),
        .count_en   ((state == ST_TW) && !wait_cpu),
        .timeout_c  (timeout_c)
    );

    always_ff @(posedge clk_cpu) begin
        if (!reset_cpu) begin
            state      <= ST_IDLE;
            cmd_q      <= '0;
            d_oe       <= 1'b0;
            gap_cnt    <= '0;
            cmd_ready  <= 1'b0;
            io_req_cpu <= 1'b1;
            rd_cpu     <= 1'b1;
            wr_cpu     <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        state     <= ST_T1;
                        cmd_ready <= 1'b0;
                        cmd_q     <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
                        d_oe      <= cmd_write;
                    end else if (gap_cnt > GAP_W'(1)) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end else begin
                        gap_cnt   <= '0;
                        cmd_ready <= 1'b1;
                    end
                end
                ST_T1: begin
                    state      <= ST_T2;
                    io_req_cpu <= 1'b0;
                    rd_cpu     <= cmd_q.write;
                    wr_cpu     <= !cmd_q.write;
                end
                ST_T2: begin
                    state <= ST_TW;
                end
                ST_TW: begin
                    if (wait_cpu) begin
                        state <= ST_T3;
                    end else if (timeout_c) begin
                        // Abort: release the bus and report an error, read data untouched.
                        state      <= ST_T4;
                        io_req_cpu <= 1'b1;
                        rd_cpu     <= 1'b1;
                        wr_cpu     <= 1'b1;
                        d_oe       <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b1;
                    end
                end
                ST_T3: begin
                    state      <= ST_T4;
                    io_req_cpu <= 1'b1;
                    rd_cpu     <= 1'b1;
                    wr_cpu     <= 1'b1;
                    d_oe       <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= 1'b0;
                    if (!cmd_q.write) begin
                        rsp_rdata <= d_cpu;
                    end
                end
                ST_T4: begin
                    state   <= ST_IDLE;
                    gap_cnt <= GAP_W'(IDLE_GAP);
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_io_initiator.sv
// Randomized scoreboard bench for z80_io_initiator against a register-file style responder.
`timescale 1ns/1ps
module tb_z80_io_initiator;

    localparam logic [7:0] LIMIT = 8'd10;

    logic       clk_cpu = 1'b0;
    logic       reset_cpu, cmd_valid, cmd_write, cmd_ready;
    logic [7:0] cmd_addr, cmd_wdata, rsp_rdata, a_cpu;
    logic       rsp_valid, rsp_err, io_req_cpu, rd_cpu, wr_cpu, wait_cpu;
    wire  [7:0] d_cpu;
    logic       drv_en;
    logic [7:0] drv_val;

    always #5 clk_cpu = ~clk_cpu;

    assign d_cpu = drv_en ? drv_val : 8'hzz;

    z80_io_initiator #(.WAIT_LIMIT(LIMIT), .IDLE_GAP(1)) dut (
        .clk_cpu(clk_cpu), .reset_cpu(reset_cpu),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .a_cpu(a_cpu), .d_cpu(d_cpu),
        .io_req_cpu(io_req_cpu), .rd_cpu(rd_cpu), .wr_cpu(wr_cpu), .wait_cpu(wait_cpu)
    );

    typedef struct {
        bit         w;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] rd;
        bit         err;
        int         len;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Responder: register file with an auto-increment window at 80h and programmable wait.
    logic [7:0] resp_mem [256];
    logic [7:0] fifo     [256];
    logic [7:0] ptr;
    logic       prev_rd;
    logic [7:0] prev_a;
    int         low_cnt;
    int         cur_n;

    always @(posedge clk_cpu) begin
        #2;
        if (!prev_rd && rd_cpu && prev_a == 8'h80) ptr = ptr + 8'd1;
        prev_rd = rd_cpu;
        prev_a  = a_cpu;
        if (!io_req_cpu) begin
            wait_cpu = (low_cnt < cur_n) ? 1'b0 : 1'b1;
            low_cnt++;
        end else begin
            wait_cpu = 1'b1;
            low_cnt  = 0;
        end
        if (!io_req_cpu && !wr_cpu) resp_mem[a_cpu] = d_cpu;
        drv_en  = !io_req_cpu && !rd_cpu;
        drv_val = (a_cpu == 8'h80) ? fifo[ptr] : resp_mem[a_cpu];
    end

    // Monitor: tracks each strobe-low window and checks it when the response appears.
    bit         in_cyc, rv_prev, a_ok, d_ok;
    int         low_len, rd_len, wr_len, hi_len;
    logic [7:0] cyc_a, t1_d, prev_d, prev_a_mon;

    always @(negedge clk_cpu) begin
        if (!reset_cpu) begin
            in_cyc  = 0;
            rv_prev = 0;
            hi_len  = 0;
        end else begin
            check_eq("strobe_rules", 32'({!rd_cpu && !wr_cpu, io_req_cpu && (!rd_cpu || !wr_cpu),
                                          !io_req_cpu && cmd_ready}), 32'd0);
            if (!io_req_cpu) begin
                if (!in_cyc) begin
                    in_cyc  = 1;
                    check_eq("idle_gap", 32'(hi_len >= 2), 32'd1);
                    low_len = 0; rd_len = 0; wr_len = 0;
                    cyc_a   = a_cpu;
                    a_ok    = (prev_a_mon == a_cpu);
                    t1_d    = prev_d;
                    d_ok    = 1;
                end
                low_len++;
                if (!rd_cpu) rd_len++;
                if (!wr_cpu) wr_len++;
                if (a_cpu != cyc_a) a_ok = 0;
                if (!wr_cpu && d_cpu !== t1_d) d_ok = 0;
                if (!rd_cpu && d_cpu !== drv_val) d_ok = 0;
                hi_len = 0;
            end else begin
                in_cyc = 0;
                hi_len++;
            end
            if (rsp_valid) begin
                check_eq("rsp_pulse_width", 32'(rv_prev), 32'd0);
                if (sbq.size() == 0) begin
                    check_eq("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
                    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
                    check_eq("strobe_len", 32'(low_len), 32'(e.len));
                    check_eq("rw_strobe_len", 32'(e.w ? wr_len : rd_len), 32'(e.len));
                    check_eq("other_strobe_len", 32'(e.w ? rd_len : wr_len), 32'd0);
                    check_eq("bus_addr", 32'(cyc_a), 32'(e.a));
                    check_eq("addr_held", 32'({a_ok, a_cpu == e.a}), 32'd3);
                    check_eq("data_bus", 32'(d_ok), 32'd1);
                    if (e.w) check_eq("t1_wdata", 32'(t1_d), 32'(e.wd));
                    check_eq("t4_strobes", 32'({io_req_cpu, rd_cpu, wr_cpu}), 32'd7);
                end
            end
            rv_prev = rsp_valid;
        end
        prev_d     = d_cpu;
        prev_a_mon = a_cpu;
    end

    // Reference model: plain memory + pointer, expected timing from the wait count.
    logic [7:0] model_mem [256];
    logic [7:0] ptr_m;
    logic [7:0] last_rdata;

    task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] wd,
                         input int n, input bit push);
        exp_t       e;
        int         k;
        int         tw_low;
        logic [7:0] v;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = wd;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk_cpu);
            k++;
        end
        if (!cmd_ready) begin
            check_eq("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        cur_n  = n;
        tw_low = (n > 0) ? n - 1 : 0;
        e.w    = w;
        e.a    = a;
        e.wd   = wd;
        e.err  = (tw_low >= int'(LIMIT));
        e.len  = e.err ? 1 + int'(LIMIT) : tw_low + 3;
        if (w) begin
            model_mem[a] = wd;
        end else begin
            v = (a == 8'h80) ? fifo[ptr_m] : model_mem[a];
            if (a == 8'h80) ptr_m = ptr_m + 8'd1;
            if (!e.err) last_rdata = v;
        end
        e.rd = last_rdata;
        if (push) sbq.push_back(e);
        @(posedge clk_cpu);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
        @(negedge clk_cpu);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 500) begin
            @(negedge clk_cpu);
            k++;
        end
        check_eq("drain_timeout", 32'(sbq.size()), 32'd0);
        repeat (3) @(negedge clk_cpu);
    endtask

    initial begin
        logic [7:0] v;
        bit         w;
        logic [7:0] a;
        int         n;
        int         sel;
        reset_cpu = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        wait_cpu = 1'b1; drv_en = 1'b0; drv_val = '0;
        ptr = '0; ptr_m = '0; prev_rd = 1'b1; prev_a = '0; low_cnt = 0; cur_n = 0;
        last_rdata = 8'h00; prev_d = '0; prev_a_mon = '0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            resp_mem[i]  = v;
            model_mem[i] = v;
            fifo[i]      = 8'($urandom);
        end
        resp_mem[8'h8B]  = 8'hFA;
        model_mem[8'h8B] = 8'hFA;

        repeat (3) @(negedge clk_cpu);
        check_eq("rst_strobes", 32'({io_req_cpu, rd_cpu, wr_cpu}), 32'd7);
        check_eq("rst_addr", 32'(a_cpu), 32'h00);
        check_eq("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        check_eq("rst_rdata", 32'(rsp_rdata), 32'h00);
        check_eq("rst_ready", 32'(cmd_ready), 32'd0);
        reset_cpu = 1'b1;
        @(negedge clk_cpu);
        check_eq("ready_after_rst", 32'(cmd_ready), 32'd1);

        issue(1'b1, 8'h84, 8'h5A, 0, 1'b1);
        issue(1'b0, 8'h8B, 8'h00, 0, 1'b1);
        issue(1'b0, 8'h80, 8'h00, 0, 1'b1);
        issue(1'b0, 8'h80, 8'h00, 0, 1'b1);
        issue(1'b0, 8'h84, 8'h00, 5, 1'b1);
        issue(1'b0, 8'h8B, 8'h00, 20, 1'b1);
        drain();

        // Reset while a write sits in TW.
        issue(1'b1, 8'h42, 8'h3C, 20, 1'b0);
        repeat (2) @(negedge clk_cpu);
        check_eq("pre_rst_io_low", 32'(io_req_cpu), 32'd0);
        reset_cpu = 1'b0;
        @(negedge clk_cpu);
        check_eq("midrst_strobes", 32'({io_req_cpu, rd_cpu, wr_cpu}), 32'd7);
        check_eq("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        check_eq("midrst_ready", 32'(cmd_ready), 32'd0);
        check_eq("midrst_rdata", 32'(rsp_rdata), 32'h00);
        last_rdata = 8'h00;
        cur_n = 0;
        reset_cpu = 1'b1;
        @(negedge clk_cpu);
        check_eq("midrst_ready_release", 32'(cmd_ready), 32'd1);

        for (int k = 0; k < 150; k++) begin
            w   = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            a   = (sel == 0) ? 8'h80 : (sel == 1) ? 8'h84 :
                  (sel == 2) ? 8'(8'h80 + $urandom_range(0, 35)) : 8'($urandom);
            n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14))
                                              : int'($urandom_range(0, 4));
            issue(w, a, 8'($urandom), n, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk_cpu);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
